// File: rtl/serial_adder_n.sv
// Digit-serial adder/subtractor: one DIGIT-bit adder slice with a registered carry
// walks WIDTH-bit operands LSB-first under a start/busy/done handshake.
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-1:0]   res_r;
  logic [WIDTH-1:0]   res_nxt_s;
  logic [CW-1:0]      cnt_r;
  logic               carry_r;
  logic               carry_nxt_s;
  logic [DIGIT-1:0]   dsum_s;
  logic               msb_cin_s;
  logic               last_s;
  logic               load_s;
  logic               busy_nxt_s;
  logic               done_nxt_s;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   sum_r;
  logic               c_out_r;
  logic               ovf_r;

  function automatic logic [DIGIT:0] slice_add(
    input logic [DIGIT-1:0] x,
    input logic [DIGIT-1:0] y,
    input logic             ci
  );
    return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
  endfunction

  // Adder slice, result shift and carry into the top bit of the slice.
  always_comb begin
    {carry_nxt_s, dsum_s} = slice_add(a_sh_r[DIGIT-1:0], b_sh_r[DIGIT-1:0], carry_r);
    // On the final step the slice MSB is operand bit WIDTH-1, so this is the carry into it.
    msb_cin_s = a_sh_r[DIGIT-1] ^ b_sh_r[DIGIT-1] ^ dsum_s[DIGIT-1];
    res_nxt_s = res_r >> DIGIT;
    res_nxt_s[WIDTH-1 -: DIGIT] = dsum_s;
    last_s = (cnt_r == CW'(STEPS - 1));
    load_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_RUN;
        else       state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_nxt_s = ST_DONE;
        else        state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (start) state_nxt_s = ST_RUN;
        else       state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state so they can be registered.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_RUN:  busy_nxt_s = 1'b1;
      ST_DONE: done_nxt_s = 1'b1;
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  // Operand shifters, carry, step counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      res_r   <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (load_s) begin
      a_sh_r  <= a;
      b_sh_r  <= sub ? ~b : b;
      carry_r <= sub ? 1'b1 : c_in;
      cnt_r   <= '0;
    end else if (state_r == ST_RUN) begin
      a_sh_r  <= a_sh_r >> DIGIT;
      b_sh_r  <= b_sh_r >> DIGIT;
      res_r   <= res_nxt_s;
      carry_r <= carry_nxt_s;
      cnt_r   <= cnt_r + CW'(1);
      if (last_s) begin
        sum_r   <= res_nxt_s;
        c_out_r <= carry_nxt_s;
        ovf_r   <= msb_cin_s ^ carry_nxt_s;
      end else begin
        sum_r   <= sum_r;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign sum   = sum_r;
  assign c_out = c_out_r;
  assign ovf   = ovf_r;

  serial_adder_n_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .busy (busy_r),
    .done (done_r)
  );

endmodule

// Handshake invariants for serial_adder_n.
module serial_adder_n_chk (
  input logic clk,
  input logic rst,
  input logic busy,
  input logic done
);

  a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy && done));
  a_done_pulse:     assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule

// File: tb/tb_serial_adder_n.sv
// Randomised and directed bench for serial_adder_n at three widths/slice sizes,
// checked against an arithmetic reference model.
module tb_serial_adder_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start0, sub0, cin0, busy0, done0, co0, ov0;
  logic [7:0] a0, b0, sum0;
  logic       start1, sub1, cin1, busy1, done1, co1, ov1;
  logic [7:0] a1, b1, sum1;
  logic       start2, sub2, cin2, busy2, done2, co2, ov2;
  logic [0:0] a2, b2, sum2;

  int total = 0;
  int bad   = 0;

  serial_adder_n #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst(rst), .start(start0), .sub(sub0), .a(a0), .b(b0), .c_in(cin0),
    .busy(busy0), .done(done0), .sum(sum0), .c_out(co0), .ovf(ov0));

  serial_adder_n #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .c_in(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(co1), .ovf(ov1));

  serial_adder_n #(.WIDTH(1), .DIGIT(1)) u_w1d1 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2), .c_in(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .c_out(co2), .ovf(ov2));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, c_out, sum} from plain integer arithmetic on w-bit operands.
  function automatic logic [9:0] model(input int w, input logic sb, input logic [7:0] aa,
                                       input logic [7:0] bb, input logic ci);
    int mask, av, bv, cv, full, s, sa, sbv, ss;
    logic co, ov;
    mask = (1 << w) - 1;
    av   = int'(aa) & mask;
    bv   = sb ? (int'(~bb) & mask) : (int'(bb) & mask);
    cv   = sb ? 1 : int'(ci);
    full = av + bv + cv;
    s    = full & mask;
    co   = ((full >> w) & 1) != 0;
    sa   = (av >> (w - 1)) & 1;
    sbv  = (bv >> (w - 1)) & 1;
    ss   = (s >> (w - 1)) & 1;
    ov   = (sa == sbv) && (ss != sa);
    return {ov, co, 8'(s)};
  endfunction

  task automatic drive(input int sel, input logic st, input logic sb, input logic [7:0] aa,
                       input logic [7:0] bb, input logic ci);
    case (sel)
      0: begin start0 = st; sub0 = sb; a0 = aa; b0 = bb; cin0 = ci; end
      1: begin start1 = st; sub1 = sb; a1 = aa; b1 = bb; cin1 = ci; end
      default: begin start2 = st; sub2 = sb; a2 = aa[0:0]; b2 = bb[0:0]; cin2 = ci; end
    endcase
  endtask

  task automatic get(input int sel, output logic bz, output logic dn, output logic [7:0] sm,
                     output logic co, output logic ov);
    case (sel)
      0: begin bz = busy0; dn = done0; sm = sum0; co = co0; ov = ov0; end
      1: begin bz = busy1; dn = done1; sm = sum1; co = co1; ov = ov1; end
      default: begin bz = busy2; dn = done2; sm = {7'b0, sum2}; co = co2; ov = ov2; end
    endcase
  endtask

  task automatic drive_junk(input int sel, input logic st);
    drive(sel, st, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  // One operation: start, wait for done, check latency, busy length and results.
  task automatic do_op(input int sel, input logic sb, input logic [7:0] aa, input logic [7:0] bb,
                       input logic ci, input bit mid_pulse,
                       output logic [7:0] osum, output logic oco, output logic oov);
    int steps, w, lat, bcnt;
    logic bz, dn, co, ov;
    logic [7:0] sm;
    logic [9:0] m;
    steps = (sel == 0) ? 8 : (sel == 1) ? 2 : 1;
    w     = (sel == 2) ? 1 : 8;
    m     = model(w, sb, aa, bb, ci);
    @(negedge clk);
    drive(sel, 1'b1, sb, aa, bb, ci);
    @(posedge clk); #1;
    drive_junk(sel, 1'b0);
    lat = 0;
    bcnt = 0;
    get(sel, bz, dn, sm, co, ov);
    while (!dn && lat < 40) begin
      if (bz) bcnt++;
      @(posedge clk); #1;
      lat++;
      if (mid_pulse && lat == 2) drive_junk(sel, 1'b1);
      if (mid_pulse && lat == 3) drive_junk(sel, 1'b0);
      get(sel, bz, dn, sm, co, ov);
    end
    check_val("latency", 32'(lat), 32'(steps));
    check_val("busy_len", 32'(bcnt), 32'(steps));
    check_val("busy_at_done", 32'(bz), 32'd0);
    check_val("sum", 32'(sm), 32'(m[7:0]));
    check_val("c_out", 32'(co), 32'(m[8]));
    check_val("ovf", 32'(ov), 32'(m[9]));
    osum = sm;
    oco  = co;
    oov  = ov;
    @(posedge clk); #1;
    get(sel, bz, dn, sm, co, ov);
    check_val("done_pulse", 32'(dn), 32'd0);
    check_val("sum_hold", 32'(sm), 32'(m[7:0]));
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] s;
    logic co, ov, bz, dn;
    int t;
    logic [9:0] m1, m2;

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(2, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    get(0, bz, dn, s, co, ov);
    check_val("rst_busy", 32'(bz), 32'd0);
    check_val("rst_done", 32'(dn), 32'd0);
    check_val("rst_sum", 32'(s), 32'd0);
    check_val("rst_cout", 32'(co), 32'd0);
    check_val("rst_ovf", 32'(ov), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases with literal expectations.
    do_op(0, 1'b0, 8'h3C, 8'h5A, 1'b1, 1'b0, s, co, ov);
    check_val("d_add_sum", 32'(s), 32'h97);
    check_val("d_add_cv", 32'({co, ov}), 32'b01);
    do_op(1, 1'b1, 8'h10, 8'h20, 1'b0, 1'b0, s, co, ov);
    check_val("d_sub1_sum", 32'(s), 32'hF0);
    check_val("d_sub1_cv", 32'({co, ov}), 32'b00);
    do_op(1, 1'b1, 8'h80, 8'h01, 1'b0, 1'b0, s, co, ov);
    check_val("d_sub2_sum", 32'(s), 32'h7F);
    check_val("d_sub2_cv", 32'({co, ov}), 32'b11);
    do_op(0, 1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, s, co, ov);
    check_val("d_wrap_sum", 32'(s), 32'h00);
    check_val("d_wrap_cv", 32'({co, ov}), 32'b10);

    // Full-adder truth table on the 1-bit instance.
    for (int i = 0; i < 8; i++) begin
      logic ab, bb1, cb;
      ab  = 1'(i >> 2);
      bb1 = 1'(i >> 1);
      cb  = 1'(i);
      do_op(2, 1'b0, {7'b0, ab}, {7'b0, bb1}, cb, 1'b0, s, co, ov);
      check_val("tt_sum", 32'(s[0]), 32'(ab ^ bb1 ^ cb));
      check_val("tt_cout", 32'(co), 32'((ab & bb1) | (ab & cb) | (bb1 & cb)));
    end

    // start pulsed mid-RUN with junk operands is ignored.
    do_op(0, 1'b0, 8'h3C, 8'h5A, 1'b1, 1'b1, s, co, ov);
    check_val("mid_start_sum", 32'(s), 32'h97);

    // Back-to-back: start held high through the done cycle.
    m1 = model(8, 1'b0, 8'h12, 8'h34, 1'b0);
    m2 = model(8, 1'b1, 8'h05, 8'h09, 1'b0);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 8'h12, 8'h34, 1'b0);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 8'h05, 8'h09, 1'b0);
    t = 0;
    get(1, bz, dn, s, co, ov);
    while (!dn && t < 40) begin
      @(posedge clk); #1;
      t++;
      get(1, bz, dn, s, co, ov);
    end
    check_val("b2b_lat1", 32'(t), 32'd2);
    check_val("b2b_sum1", 32'(s), 32'(m1[7:0]));
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    t = 1;
    get(1, bz, dn, s, co, ov);
    check_val("b2b_restart_busy", 32'(bz), 32'd1);
    while (!dn && t < 40) begin
      @(posedge clk); #1;
      t++;
      get(1, bz, dn, s, co, ov);
    end
    check_val("b2b_gap", 32'(t), 32'd3);
    check_val("b2b_sum2", 32'(s), 32'(m2[7:0]));
    check_val("b2b_cv2", 32'({co, ov}), 32'({m2[8], m2[9]}));

    // Reset two cycles into RUN clears outputs immediately.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 8'h21, 8'h43, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    get(0, bz, dn, s, co, ov);
    check_val("mid_rst_busy", 32'(bz), 32'd0);
    check_val("mid_rst_done", 32'(dn), 32'd0);
    check_val("mid_rst_sum", 32'(s), 32'd0);
    check_val("mid_rst_cv", 32'({co, ov}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(0, 1'b1, 8'h55, 8'hAA, 1'b0, 1'b0, s, co, ov);

    // Randomised operations on both 8-bit instances.
    for (int k = 0; k < 40; k++) begin
      do_op(int'($urandom_range(0, 1)), 1'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), 1'b0, s, co, ov);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
